// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU: datapath widths and opcode encodings.
package alu_pkg;

  localparam int W  = 8;
  localparam int PW = 16;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SLA = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_ADD = 4'd9;
  localparam logic [3:0] OP_SUB = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_CLR = 4'd15;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit. The full 8-bit amount is used, so shifts
// saturate at 8 or more; rotates use the amount modulo 8.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] n,
  input  logic [3:0]   op,
  output logic [W-1:0] y
);

  logic         big;
  logic [2:0]   amt;
  logic [PW-1:0] rol_w;
  logic [PW-1:0] ror_w;

  assign big   = (n >= 8'd8);
  assign amt   = n[2:0];
  // A doubled copy turns rotation into a plain shift plus window select.
  assign rol_w = {a, a} << amt;
  assign ror_w = {a, a} >> amt;

  always_comb begin
    y = '0;
    case (op)
      OP_SLL, OP_SLA: y = big ? '0 : (a << amt);
      OP_SRL:         y = big ? '0 : (a >> amt);
      OP_SRA:         y = big ? {W{a[W-1]}} : W'($signed(a) >>> amt);
      OP_ROL:         y = rol_w[PW-1:W];
      OP_ROR:         y = ror_w[W-1:0];
      default:        y = '0;
    endcase
  end

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: opcode mux over logic, shift, add/sub and multiply,
// with overflow, zero and signed less-than flags, one cycle of latency.
module alu_8bit
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [3:0]    Op,
  output logic [W-1:0]  result,
  output logic [PW-1:0] product,
  output logic          OF,
  output logic          zero,
  output logic          slt
);

  logic [W-1:0]  shift_y;
  logic [W-1:0]  sum;
  logic [W-1:0]  diff;
  logic [PW-1:0] mul_full;
  logic [W-1:0]  res_d;
  logic [PW-1:0] prod_d;
  logic          of_d;
  logic          slt_d;

  alu_shifter u_shifter (
    .a  (a),
    .n  (b),
    .op (Op),
    .y  (shift_y)
  );

  assign sum      = a + b;
  assign diff     = a - b;
  assign mul_full = {{(PW-W){1'b0}}, a} * {{(PW-W){1'b0}}, b};
  assign slt_d    = ($signed(a) < $signed(b));

  always_comb begin
    res_d  = '0;
    prod_d = '0;
    of_d   = 1'b0;
    case (Op)
      OP_NOT: res_d = ~a;
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROL, OP_ROR: res_d = shift_y;
      OP_ADD: begin
        res_d = sum;
        of_d  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res_d = diff;
        of_d  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_MUL: begin
        prod_d = mul_full;
        res_d  = mul_full[W-1:0];
        of_d   = |mul_full[PW-1:W];
      end
      default: res_d = '0;
    endcase
  end

  // zero is registered from the next result, so it also clears under reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      product <= '0;
      OF      <= 1'b0;
      zero    <= 1'b0;
      slt     <= 1'b0;
    end else begin
      result  <= res_d;
      product <= prod_d;
      OF      <= of_d;
      zero    <= (res_d == '0);
      slt     <= slt_d;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed-vector bench for alu_8bit: a table of hand-computed results plus
// reset sequences around a multiply stream.
module tb_alu_8bit;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [7:0]  res;
    logic [15:0] prod;
    logic        of;
    logic        zero;
    logic        slt;
  } vec_t;

  localparam int NV = 27;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  Op;
  logic [7:0]  result;
  logic [15:0] product;
  logic        OF;
  logic        zero;
  logic        slt;

  int n_vec;
  int n_miss;
  vec_t vecs [NV];

  alu_8bit dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .Op      (Op),
    .result  (result),
    .product (product),
    .OF      (OF),
    .zero    (zero),
    .slt     (slt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] er, input logic [15:0] ep,
                       input logic eo, input logic ez, input logic es);
    n_vec++;
    if (result !== er) begin
      n_miss++;
      $display("FAIL %s result got %h expected %h", name, result, er);
    end
    if (product !== ep) begin
      n_miss++;
      $display("FAIL %s product got %h expected %h", name, product, ep);
    end
    if (OF !== eo) begin
      n_miss++;
      $display("FAIL %s OF got %b expected %b", name, OF, eo);
    end
    if (zero !== ez) begin
      n_miss++;
      $display("FAIL %s zero got %b expected %b", name, zero, ez);
    end
    if (slt !== es) begin
      n_miss++;
      $display("FAIL %s slt got %b expected %b", name, slt, es);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    //            a      b      op     res    prod       of    zero  slt
    vecs[0]  = '{8'hAA, 8'h00, 4'd0,  8'h55, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'hCC, 8'hAA, 4'd1,  8'h88, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'hCC, 8'hAA, 4'd2,  8'hEE, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'hCC, 8'h06, 4'd3,  8'h00, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{8'hCC, 8'h05, 4'd4,  8'h06, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'hCC, 8'h02, 4'd5,  8'h30, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'hCC, 8'h08, 4'd6,  8'hFF, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'hCC, 8'h07, 4'd7,  8'h66, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'hCC, 8'h08, 4'd8,  8'hCC, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{8'h0F, 8'h01, 4'd9,  8'h10, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h80, 8'h80, 4'd9,  8'h00, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{8'h0F, 8'h01, 4'd10, 8'h0E, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h0F, 8'h48, 4'd10, 8'hC7, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'h03, 8'h05, 4'd11, 8'h0F, 16'h000F, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'h46, 8'h81, 4'd11, 8'h46, 16'h2346, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{8'h46, 8'h81, 4'd15, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{8'h7F, 8'h01, 4'd9,  8'h80, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{8'h80, 8'h01, 4'd10, 8'h7F, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{8'h4C, 8'h03, 4'd6,  8'h09, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{8'hCC, 8'hC8, 4'd4,  8'h00, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{8'hCC, 8'h09, 4'd8,  8'h66, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{8'hFF, 8'h01, 4'd13, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[22] = '{8'h01, 8'h07, 4'd3,  8'h80, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{8'h80, 8'hFF, 4'd6,  8'hFF, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[24] = '{8'h81, 8'h01, 4'd7,  8'h03, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[25] = '{8'h05, 8'h05, 4'd10, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[26] = '{8'hFF, 8'hFF, 4'd11, 8'h01, 16'hFE01, 1'b1, 1'b0, 1'b0};

    // Reset with a nonzero-result operation pending: everything reads 0.
    rst = 1'b1;
    a   = 8'hAA;
    b   = 8'h00;
    Op  = 4'd0;
    step();
    check("reset", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    check("reset_hold", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back vectors, one per cycle.
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      a  = vecs[i].a;
      b  = vecs[i].b;
      Op = vecs[i].op;
      step();
      check($sformatf("vec%0d", i), vecs[i].res, vecs[i].prod,
            vecs[i].of, vecs[i].zero, vecs[i].slt);
    end

    // Reset for one edge in the middle of a multiply stream.
    a  = 8'h46;
    b  = 8'h81;
    Op = 4'd11;
    step();
    check("mul_pre_rst", 8'h46, 16'h2346, 1'b1, 1'b0, 1'b0);
    a   = 8'h03;
    b   = 8'h05;
    rst = 1'b1;
    step();
    check("mul_in_rst", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check("mul_post_rst", 8'h0F, 16'h000F, 1'b0, 1'b0, 1'b1);
    a = 8'h10;
    b = 8'h10;
    step();
    check("mul_of_edge", 8'h00, 16'h0100, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
